pkt_ingress_ctrl: RTL and testbench
===================================

# pkt_ingress_ctrl

Ingress sequencer for the packet switch. It accepts a byte stream from the source port and decodes the header to pick one of three output FIFOs. It then steers header, payload and parity bytes into that FIFO's write port, applying back-pressure when the FIFO is full. It also checks packet parity, rejects bad addresses and reports completion to the top-level status logic.

## Interface
Parameters:
- STALL_LIMIT, 32: number of consecutive full-stall cycles before timeout abort (used only with the timeout feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- packet_valid  in  1  source byte valid; byte accepted on an edge where packet_valid=1 and busy=0.
- data_in  in  8  source byte.
- fifo_full  in  3  full flags of output FIFOs 0..2.
- busy  out  1  back-pressure to the source. Combinational from registered state and fifo_full.
- data_to_fifo  out  8  registered hold byte, shared by all three FIFOs.
- write_enb  out  3  one-hot write strobe for the destination FIFO.
- pkt_done  out  1  one-cycle pulse when a packet's parity byte is written.
- parity_err  out  1  one-cycle pulse with pkt_done on a parity mismatch.
- addr_err  out  1  one-cycle pulse when a header with dest=3 is accepted.
- timeout_err  out  1  one-cycle pulse on stall abort; tied 0 when the feature is compiled out.

## Operation
- Packet format:
  - Header: [1:0] = destination 0..2; [7:2] = payload length L, 0..63.
  - Then L payload bytes.
  - Then one parity byte, equal to the XOR of the header and all payload bytes.
- Hold register: one byte plus a hold_valid bit, and a dest register.
  - write_enb[dest] = hold_valid & ~fifo_full[dest]; all other strobes are 0.
  - The hold register drains on any cycle its strobe is high.
  - A new byte may load on the same edge as a drain, giving 1 byte/cycle throughput.
- busy = (hold_valid & fifo_full[dest]) | (state==CHECK) | (state==ABORT).
- States:
  - IDLE: on an accepted header:
    - dest≠3: load hold, latch dest, set len_cnt=L, parity_acc=header, go to PAYLOAD (or PARITY if L=0).
    - dest=3: nothing loaded, pulse addr_err, set drop_cnt=L+1, go to DROP (or IDLE if that count is 0, which is impossible since L+1≥1).
  - PAYLOAD: each accepted byte loads hold, XORs into parity_acc and decrements len_cnt. Reaching 0 goes to PARITY.
  - PARITY: the accepted byte loads hold and is compared to parity_acc (mismatch flag registered); go to CHECK.
  - CHECK: busy=1. On the cycle the parity byte is written, pulse pkt_done (and parity_err if mismatched), then go to IDLE.
  - DROP: accepted bytes are discarded and decrement drop_cnt. Reaching 0 goes to IDLE.
  - ABORT: one cycle, busy=1, then go to DROP (remaining >0) or IDLE.
- Bytes with packet_valid=0 are ignored in every state; gaps inside a packet are legal.
- Packets with bad parity are still written in full; downstream discards them.

## Timing
- Reset: state=IDLE, hold_valid=0, data_to_fifo=8'h00, write_enb=0, busy=0, all pulses 0, all counters 0.
- Reset mid-packet aborts the packet immediately. The FIFOs keep any partial bytes already written.
- Latency: a byte accepted at edge N appears on data_to_fifo with its write_enb high in cycle N+1, provided the FIFO is not full.
- Full FIFO: the strobe is held low and data_to_fifo is stable. busy stays high until the cycle fifo_full drops, with no byte loss.
- Minimum packet time with no stalls is L+2 accept cycles plus 1 CHECK cycle. The next header may be accepted in the cycle after pkt_done.
- Arithmetic: len_cnt is 6 bits, drop_cnt 7 bits, parity_acc 8-bit XOR. No wrap occurs within the legal L range.

## Configuration
- PKT_INGRESS_TIMEOUT_EN defined:
  - A stall counter increments on each cycle with hold_valid & fifo_full[dest] and clears otherwise.
  - On reaching STALL_LIMIT, the hold byte is discarded and timeout_err pulses.
  - The block then goes to ABORT with drop_cnt = unreceived bytes of the packet, or 0 if in CHECK.
- Undefined: no stall counter. The block stalls indefinitely and timeout_err is tied 0.

## Structure
- Shared package pkt_switch_pkg:
  - State enum.
  - Constants NUM_PORTS=3, ADDR_W=2, LEN_W=6, INVALID_ADDR=2'd3.
  - Header field slice helpers.
- One sub-module: pkt_ingress_hold (hold register, dest-indexed strobe and busy term). The FSM, counters and parity logic stay in the top.

## Test plan
- Header 8'h0D, payload 11 22 33, parity 0D, FIFOs empty: write_enb=3'b010 for 5 consecutive cycles. Bytes 0D 11 22 33 0D are written, then pkt_done=1 and parity_err=0.
- Same packet with parity 8'hFF: all 5 bytes are written to FIFO1, and pkt_done=1 together with parity_err=1.
- Header 8'h07 (dest 3, L=1), then AA, BB: addr_err pulses once, write_enb stays 0 and busy stays 0. The block returns to IDLE and the next header is accepted.
- Header 8'h04 (dest 0, L=1) with fifo_full[0]=1 for 5 cycles after the header: busy=1, data_to_fifo holds 04 and the source holds its byte. Draining resumes with no byte lost or duplicated.
- With PKT_INGRESS_TIMEOUT_EN: fifo_full[2] is stuck at 1 after header 8'h0A:
  - timeout_err pulses after 32 stall cycles.
  - The remaining 3 bytes are dropped, pkt_done never fires, and the block returns to IDLE.
- Reset asserted mid-payload: the next cycle shows all outputs at their reset values, and a fresh header is accepted normally.

Source files
------------

// File: rtl/pkt_switch_pkg.sv
// Shared types and constants for the packet switch ingress path.
// Header layout: [1:0] destination port, [7:2] payload length.
package pkt_switch_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned LEN_W     = 6;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StParity,
    StCheck,
    StDrop,
    StAbort
  } ingress_state_e;

  function automatic logic [ADDR_W-1:0] hdr_dest(input logic [7:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:ADDR_W];
  endfunction

endpackage

// File: rtl/pkt_ingress_hold.sv
// Single-byte hold stage in front of the output FIFOs: stores one byte and its
// destination, raises the strobe of that FIFO when it has room, reports a stall otherwise.
module pkt_ingress_hold
  import pkt_switch_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 dest_load_i,
  input  logic                 discard_i,
  input  logic [7:0]           data_i,
  input  logic [ADDR_W-1:0]    dest_i,
  input  logic [NUM_PORTS-1:0] fifo_full_i,
  output logic [7:0]           data_o,
  output logic [NUM_PORTS-1:0] write_enb_o,
  output logic                 stall_o
);

  logic [7:0]        data_q;
  logic [ADDR_W-1:0] dest_q;
  logic              valid_q;
  logic              drain;

  always_comb begin
    write_enb_o = '0;
    stall_o     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (valid_q && (dest_q == ADDR_W'(i))) begin
        write_enb_o[i] = ~fifo_full_i[i];
        stall_o        = fifo_full_i[i];
      end
    end
  end

  assign drain  = |write_enb_o;
  assign data_o = data_q;

  // A load may coincide with a drain, keeping one byte per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= 8'h00;
      dest_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (drain || discard_i) begin
        valid_q <= 1'b0;
      end
      if (dest_load_i) begin
        dest_q <= dest_i;
      end
    end
  end

endmodule

// File: rtl/pkt_ingress_ctrl.sv
// Ingress sequencer: decodes the header, steers bytes to one of three FIFOs, checks parity.
// Define PKT_INGRESS_TIMEOUT_EN to abort packets stalled for STALL_LIMIT cycles.
module pkt_ingress_ctrl
  import pkt_switch_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 packet_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic [7:0]           data_to_fifo,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic                 timeout_err
);

  ingress_state_e    state_q;
  logic [LEN_W-1:0]  len_cnt_q;
  logic [LEN_W:0]    drop_cnt_q;
  logic [7:0]        parity_acc_q;
  logic              mismatch_q;
  logic              addr_err_q;
  logic              timeout_err_q;

  logic              accept;
  logic              stall;
  logic              hold_write;
  logic              hold_load;
  logic              dest_load;
  logic              timeout_hit;
  logic [ADDR_W-1:0] in_dest;
  logic [LEN_W-1:0]  in_len;

  assign in_dest    = hdr_dest(data_in);
  assign in_len     = hdr_len(data_in);
  assign busy       = stall | (state_q == StCheck) | (state_q == StAbort);
  assign accept     = packet_valid & ~busy;
  assign hold_write = |write_enb;
  assign dest_load  = accept & (state_q == StIdle) & (in_dest != INVALID_ADDR);
  assign hold_load  = dest_load | (accept & ((state_q == StPayload) | (state_q == StParity)));

  assign pkt_done    = (state_q == StCheck) & hold_write;
  assign parity_err  = pkt_done & mismatch_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_err_q;

  pkt_ingress_hold u_hold (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (hold_load),
    .dest_load_i (dest_load),
    .discard_i   (timeout_hit),
    .data_i      (data_in),
    .dest_i      (in_dest),
    .fifo_full_i (fifo_full),
    .data_o      (data_to_fifo),
    .write_enb_o (write_enb),
    .stall_o     (stall)
  );

`ifdef PKT_INGRESS_TIMEOUT_EN
  localparam int unsigned StallCntW = $clog2(STALL_LIMIT + 1);

  logic [StallCntW-1:0] stall_cnt_q;

  assign timeout_hit = stall & (stall_cnt_q == StallCntW'(STALL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || !stall || timeout_hit) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      len_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      parity_acc_q  <= 8'h00;
      mismatch_q    <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      if (timeout_hit) begin
        // Drop whatever the source still owes for this packet.
        timeout_err_q <= 1'b1;
        state_q       <= StAbort;
        unique case (state_q)
          StPayload: drop_cnt_q <= (LEN_W + 1)'(len_cnt_q) + 7'd1;
          StParity:  drop_cnt_q <= 7'd1;
          default:   drop_cnt_q <= '0;
        endcase
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              if (in_dest == INVALID_ADDR) begin
                addr_err_q <= 1'b1;
                drop_cnt_q <= {1'b0, in_len} + 7'd1;
                state_q    <= StDrop;
              end else begin
                len_cnt_q    <= in_len;
                parity_acc_q <= data_in;
                state_q      <= (in_len == '0) ? StParity : StPayload;
              end
            end
          end
          StPayload: begin
            if (accept) begin
              parity_acc_q <= parity_acc_q ^ data_in;
              len_cnt_q    <= len_cnt_q - 1'b1;
              if (len_cnt_q == 6'd1) state_q <= StParity;
            end
          end
          StParity: begin
            if (accept) begin
              mismatch_q <= (data_in != parity_acc_q);
              state_q    <= StCheck;
            end
          end
          StCheck: begin
            if (hold_write) state_q <= StIdle;
          end
          StDrop: begin
            if (accept) begin
              drop_cnt_q <= drop_cnt_q - 1'b1;
              if (drop_cnt_q == 7'd1) state_q <= StIdle;
            end
          end
          StAbort: begin
            state_q <= (drop_cnt_q != '0) ? StDrop : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_ingress_ctrl.sv
// Bench for pkt_ingress_ctrl: directed cycle-exact scenarios plus random packets checked
// against a packet-level scoreboard of expected FIFO writes.
module tb_pkt_ingress_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       packet_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [7:0] data_to_fifo;
  logic [2:0] write_enb;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       timeout_err;

  typedef struct packed {
    logic [1:0] dest;
    logic [7:0] data;
    logic       last;
    logic       bad;
  } wr_t;

  typedef logic [7:0] byte_q_t[$];

  wr_t     exp_q[$];
  int      exp_addr_err  = 0;
  int      seen_addr_err = 0;
  int      checks        = 0;
  int      errors        = 0;
  wr_t     mon_e;
  logic [2:0] mon_oh;

  pkt_ingress_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .packet_valid (packet_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .data_to_fifo (data_to_fifo),
    .write_enb    (write_enb),
    .pkt_done     (pkt_done),
    .parity_err   (parity_err),
    .addr_err     (addr_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; caller checks at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] ff);
    @(posedge clk);
    #1;
    packet_valid = v;
    data_in      = d;
    fifo_full    = ff;
    @(negedge clk);
  endtask

  // Packet-level reference: valid packets write every byte to their FIFO, dest 3 writes nothing.
  task automatic model_pkt(input byte_q_t b);
    logic [1:0] dest;
    int         len;
    logic [7:0] x;
    wr_t        e;
    dest = b[0][1:0];
    len  = int'(b[0][7:2]);
    if (dest == 2'd3) begin
      exp_addr_err++;
      return;
    end
    x = 8'h00;
    for (int i = 0; i <= len; i++) x = x ^ b[i];
    for (int i = 0; i < len + 2; i++) begin
      e.dest = dest;
      e.data = b[i];
      e.last = (i == len + 1);
      e.bad  = (b[len + 1] != x);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (addr_err === 1'b1) seen_addr_err++;
      if (write_enb !== 3'b000) begin
        check("wr_no_full", 32'(write_enb & fifo_full), 32'd0);
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e  = exp_q.pop_front();
          mon_oh = 3'b001 << mon_e.dest;
          check("wr_dest", 32'(write_enb), 32'(mon_oh));
          check("wr_data", 32'(data_to_fifo), 32'(mon_e.data));
          check("wr_done", 32'(pkt_done), 32'(mon_e.last));
          check("wr_perr", 32'(parity_err), 32'(mon_e.last & mon_e.bad));
        end
      end else begin
        check("done_no_write", 32'(pkt_done), 32'd0);
        check("perr_no_write", 32'(parity_err), 32'd0);
      end
    end
  end

  // Back-to-back packet on empty FIFOs with cycle-exact expectations.
  task automatic run_exact(input byte_q_t b, input int dest, input logic bad);
    int         n;
    logic [2:0] oh;
    n  = b.size();
    oh = 3'b001 << dest;
    model_pkt(b);
    for (int i = 0; i <= n; i++) begin
      cycle(i < n, (i < n) ? b[i] : 8'h00, 3'b000);
      if (i > 0) begin
        check("ex_we", 32'(write_enb), 32'(oh));
        check("ex_data", 32'(data_to_fifo), 32'(b[i-1]));
      end else begin
        check("ex_we_first", 32'(write_enb), 32'd0);
      end
      check("ex_done", 32'(pkt_done), 32'(i == n));
      check("ex_perr", 32'(parity_err), 32'((i == n) && bad));
      check("ex_busy", 32'(busy), 32'(i == n));
    end
    cycle(1'b0, 8'h00, 3'b000);
    check("ex_we_after", 32'(write_enb), 32'd0);
    check("ex_busy_after", 32'(busy), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rnd);
    logic ok;
    int   gaps;
    ok   = 1'b0;
    gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    for (int g = 0; g < gaps; g++) cycle(1'b0, 8'h00, rnd ? 3'($urandom & $urandom) : 3'b000);
    for (int n = 0; n < 200; n++) begin
      cycle(1'b1, b, rnd ? 3'($urandom & $urandom) : 3'b000);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_bound", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycle(1'b0, 8'h00, 3'b000);
    cycle(1'b0, 8'h00, 3'b000);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    byte_q_t    b;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] x;
    logic       bad;

    reset        = 1'b1;
    packet_valid = 1'b0;
    data_in      = 8'h00;
    fifo_full    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data_to_fifo), 32'd0);
    check("rst_we", 32'(write_enb), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_aerr", 32'(addr_err), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);

    // Good and bad parity to FIFO1.
    b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    run_exact(b, 1, 1'b0);
    b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
    run_exact(b, 1, 1'b1);

    // Invalid destination: dropped silently apart from addr_err.
    b = '{8'h07, 8'hAA, 8'hBB};
    model_pkt(b);
    cycle(1'b1, 8'h07, 3'b000);
    check("da_busy0", 32'(busy), 32'd0);
    cycle(1'b1, 8'hAA, 3'b000);
    check("da_aerr", 32'(addr_err), 32'd1);
    check("da_we1", 32'(write_enb), 32'd0);
    check("da_busy1", 32'(busy), 32'd0);
    cycle(1'b1, 8'hBB, 3'b000);
    check("da_aerr_once", 32'(addr_err), 32'd0);
    check("da_we2", 32'(write_enb), 32'd0);
    check("da_busy2", 32'(busy), 32'd0);
    b = '{8'h01, 8'h01};
    run_exact(b, 1, 1'b0);

    // FIFO0 full for 5 cycles right after the header.
    b = '{8'h04, 8'h5A, 8'h5E};
    model_pkt(b);
    cycle(1'b1, 8'h04, 3'b000);
    check("st_busy0", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h5A, 3'b001);
      check("st_busy", 32'(busy), 32'd1);
      check("st_we", 32'(write_enb), 32'd0);
      check("st_hold", 32'(data_to_fifo), 32'h04);
    end
    cycle(1'b1, 8'h5A, 3'b000);
    check("st_rel_we", 32'(write_enb), 32'd1);
    check("st_rel_busy", 32'(busy), 32'd0);
    cycle(1'b1, 8'h5E, 3'b000);
    check("st_pay", 32'(data_to_fifo), 32'h5A);
    cycle(1'b0, 8'h00, 3'b000);
    check("st_par", 32'(data_to_fifo), 32'h5E);
    check("st_done", 32'(pkt_done), 32'd1);
    cycle(1'b0, 8'h00, 3'b000);
    check("st_idle_busy", 32'(busy), 32'd0);

`ifdef PKT_INGRESS_TIMEOUT_EN
    // FIFO2 stuck full: 32 stall cycles, abort, 3 owed bytes dropped.
    cycle(1'b1, 8'h0A, 3'b000);
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b1, 8'h55, 3'b100);
      check("to_busy", 32'(busy), 32'd1);
      check("to_terr_low", 32'(timeout_err), 32'd0);
    end
    cycle(1'b1, 8'h55, 3'b100);
    check("to_terr", 32'(timeout_err), 32'd1);
    check("to_abort_busy", 32'(busy), 32'd1);
    check("to_abort_we", 32'(write_enb), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h55, 3'b100);
      check("to_drop_busy", 32'(busy), 32'd0);
      check("to_drop_terr", 32'(timeout_err), 32'd0);
    end
    b = '{8'h01, 8'h01};
    run_exact(b, 1, 1'b0);
`endif

    // Reset in the middle of a payload.
    b = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h0C};
    model_pkt(b);
    cycle(1'b1, 8'h0C, 3'b000);
    cycle(1'b1, 8'h01, 3'b000);
    cycle(1'b1, 8'h02, 3'b000);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    packet_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_data", 32'(data_to_fifo), 32'd0);
    check("mr_we", 32'(write_enb), 32'd0);
    check("mr_done", 32'(pkt_done), 32'd0);
    check("mr_perr", 32'(parity_err), 32'd0);
    check("mr_aerr", 32'(addr_err), 32'd0);
    check("mr_terr", 32'(timeout_err), 32'd0);
    b = '{8'h05, 8'hAA, 8'hAF};
    run_exact(b, 1, 1'b0);

    // Random packets, random gaps and random back-pressure.
    for (int p = 0; p < 40; p++) begin
      dest = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      len  = 6'($urandom_range(0, 6));
      bad  = ($urandom_range(0, 3) == 0);
      b.delete();
      b.push_back({len, dest});
      x = {len, dest};
      for (int i = 0; i < int'(len); i++) begin
        b.push_back(8'($urandom));
        x = x ^ b[i + 1];
      end
      b.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
      model_pkt(b);
      for (int i = 0; i < b.size(); i++) send_byte(b[i], 1'b1);
    end
    drain();
    check("addr_err_count", 32'(seen_addr_err), 32'(exp_addr_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
